alu_ctrl_seq: RTL and testbench

- Registered, parametrised ALU control stage between decode and execute.
- Decodes opcode/func/immediate into ALU control signals and holds them in an output register with a valid/ready handshake.
- Datapath width is generic. Shifts larger than the per-cycle shifter limit are split into several passes, so a narrow shifter can serve a wide datapath.

---
 rtl/alu_ctrl_seq_if.sv | 35 +++
 rtl/alu_ctrl_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_seq_if.sv
// Handshake and control-word bundle between decode, the ALU control stage and execute.
interface alu_ctrl_seq_if #(
  parameter int unsigned SHAMT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [4:0]         opcode;
  logic [1:0]         func;
  logic [SHAMT_W-1:0] immd;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         alu_op;
  logic               inv_a;
  logic               inv_b;
  logic               cin;
  logic [SHAMT_W-1:0] shamt;
  logic               flip_1;
  logic               flip_2;
  logic               shift;
  logic               slbi;
  logic               last_pass;
  logic               illegal;

  modport master (
    output in_valid, opcode, func, immd, out_ready,
    input  in_ready, out_valid, alu_op, inv_a, inv_b, cin, shamt,
           flip_1, flip_2, shift, slbi, last_pass, illegal
  );

  modport slave (
    input  in_valid, opcode, func, immd, out_ready,
    output in_ready, out_valid, alu_op, inv_a, inv_b, cin, shamt,
           flip_1, flip_2, shift, slbi, last_pass, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control stage: decodes opcode/func/immd into a control word and splits
// shifts wider than STEP_MAX into several passes over a valid/ready handshake.
module alu_ctrl_seq #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SHAMT_W  = $clog2(DATA_W),
  parameter int unsigned STEP_MAX = DATA_W - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  alu_ctrl_seq_if.slave bus
);

  localparam logic [SHAMT_W-1:0] StepMax  = SHAMT_W'(STEP_MAX);
  localparam logic [SHAMT_W-1:0] SlbiShmt = SHAMT_W'(DATA_W / 2);

  typedef enum logic [1:0] {StIdle, StIssue, StIter} state_e;

  // slbi here marks an SLBI op; the slbi output is only raised on its final pass.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       inv_a;
    logic       inv_b;
    logic       cin;
    logic       flip;
    logic       shift;
    logic       slbi;
    logic       illegal;
  } ctrl_t;

  state_e             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  ctrl_t              dec_ctrl;
  logic [SHAMT_W-1:0] dec_req;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               slbi_q, slbi_d;
  logic               last_q, last_d;
  logic               out_valid;
  logic               in_ready;
  logic               accept;
  logic               consume;

  function automatic logic [SHAMT_W-1:0] chunk(input logic [SHAMT_W-1:0] r);
    return (r > StepMax) ? StepMax : r;
  endfunction

  // Instruction decode; dec_req is the total requested shift (0 for non-shifts).
  always_comb begin
    dec_ctrl = '0;
    dec_req  = '0;
    unique case (bus.opcode)
      5'b01000, 5'b10000, 5'b10001, 5'b10011, 5'b11001, 5'b11111: begin
        dec_ctrl.alu_op = 3'b100;
      end
      5'b01001, 5'b11100: begin
        dec_ctrl.alu_op = 3'b100;
        dec_ctrl.inv_a  = 1'b1;
        dec_ctrl.cin    = 1'b1;
      end
      5'b11101, 5'b11110: begin
        dec_ctrl.alu_op = 3'b100;
        dec_ctrl.inv_b  = 1'b1;
        dec_ctrl.cin    = 1'b1;
      end
      5'b01010: dec_ctrl.alu_op = 3'b110;
      5'b01011: begin
        dec_ctrl.alu_op = 3'b111;
        dec_ctrl.inv_b  = 1'b1;
      end
      5'b11011: begin
        case (bus.func)
          2'b00: dec_ctrl.alu_op = 3'b100;
          2'b01: begin
            dec_ctrl.alu_op = 3'b100;
            dec_ctrl.inv_a  = 1'b1;
            dec_ctrl.cin    = 1'b1;
          end
          2'b10: dec_ctrl.alu_op = 3'b110;
          default: begin
            dec_ctrl.alu_op = 3'b111;
            dec_ctrl.inv_b  = 1'b1;
          end
        endcase
      end
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        dec_ctrl.alu_op = {1'b0, bus.opcode[1:0]};
        dec_ctrl.flip   = (bus.opcode[1:0] == 2'b10);
        dec_ctrl.shift  = 1'b1;
        dec_req         = bus.immd;
      end
      5'b11010: begin
        dec_ctrl.alu_op = {1'b0, bus.func};
        dec_ctrl.flip   = (bus.func == 2'b10);
        dec_ctrl.shift  = 1'b1;
        dec_req         = bus.immd;
      end
      5'b10010: begin
        dec_ctrl.alu_op = 3'b001;
        dec_ctrl.shift  = 1'b1;
        dec_ctrl.slbi   = 1'b1;
        dec_req         = SlbiShmt;
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  assign out_valid = (state_q != StIdle);
  assign in_ready  = rst_n && !flush && (!out_valid || (bus.out_ready && last_q));
  assign accept    = bus.in_valid && in_ready;
  assign consume   = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    rem_d   = rem_q;
    shamt_d = shamt_q;
    slbi_d  = slbi_q;
    last_d  = last_q;
    if (flush) begin
      state_d = StIdle;
      rem_d   = '0;
    end else if (accept) begin
      ctrl_d  = dec_ctrl;
      shamt_d = chunk(dec_req);
      rem_d   = dec_req - shamt_d;
      last_d  = (rem_d == '0);
      slbi_d  = dec_ctrl.slbi && last_d;
      state_d = last_d ? StIssue : StIter;
    end else if (consume) begin
      if (state_q == StIter) begin
        shamt_d = chunk(rem_q);
        rem_d   = rem_q - shamt_d;
        last_d  = (rem_d == '0);
        slbi_d  = ctrl_q.slbi && last_d;
        state_d = last_d ? StIssue : StIter;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      rem_q   <= '0;
      shamt_q <= '0;
      slbi_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      rem_q   <= rem_d;
      shamt_q <= shamt_d;
      slbi_q  <= slbi_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.alu_op    = ctrl_q.alu_op;
  assign bus.inv_a     = ctrl_q.inv_a;
  assign bus.inv_b     = ctrl_q.inv_b;
  assign bus.cin       = ctrl_q.cin;
  assign bus.shamt     = shamt_q;
  assign bus.flip_1    = ctrl_q.flip;
  assign bus.flip_2    = ctrl_q.flip;
  assign bus.shift     = ctrl_q.shift;
  assign bus.slbi      = slbi_q;
  assign bus.last_pass = last_q;
  assign bus.illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: a narrow-shifter instance (STEP_MAX=4) and a full-width one
// (STEP_MAX=15) share stimulus and are checked against a pass-level model every cycle.
module tb_alu_ctrl_seq;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [4:0] opcode = '0;
  logic [1:0] func = '0;
  logic [3:0] immd = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.SHAMT_W(SW)) bus_a ();
  alu_ctrl_seq_if #(.SHAMT_W(SW)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.opcode    = opcode;
  assign bus_a.func      = func;
  assign bus_a.immd      = immd;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.opcode    = opcode;
  assign bus_b.func      = func;
  assign bus_b.immd      = immd;
  assign bus_b.out_ready = 1'b1;

  alu_ctrl_seq #(.DATA_W(DW), .SHAMT_W(SW), .STEP_MAX(4)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus_a)
  );

  alu_ctrl_seq #(.DATA_W(DW), .SHAMT_W(SW), .STEP_MAX(15)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus_b)
  );

  logic [15:0] obs [2];
  logic        ov [2];
  logic        ir [2];
  logic        orr [2];
  assign obs[0] = {bus_a.alu_op, bus_a.inv_a, bus_a.inv_b, bus_a.cin, bus_a.shamt, bus_a.flip_1,
                   bus_a.flip_2, bus_a.shift, bus_a.slbi, bus_a.last_pass, bus_a.illegal};
  assign obs[1] = {bus_b.alu_op, bus_b.inv_a, bus_b.inv_b, bus_b.cin, bus_b.shamt, bus_b.flip_1,
                   bus_b.flip_2, bus_b.shift, bus_b.slbi, bus_b.last_pass, bus_b.illegal};
  assign ov[0]  = bus_a.out_valid;
  assign ov[1]  = bus_b.out_valid;
  assign ir[0]  = bus_a.in_ready;
  assign ir[1]  = bus_b.in_ready;
  assign orr[0] = out_ready;
  assign orr[1] = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one in-flight instruction per DUT, tracked by pass index ----------
  typedef struct {
    logic [2:0] alu_op;
    bit         inv_a, inv_b, cin, flip, shift, slbi, illegal;
    int         r;
  } op_t;

  op_t cur [2];
  int  k [2];
  bit  busy [2];
  bit  zeros [2];

  function automatic int stepm(input int m);
    return (m == 0) ? 4 : 15;
  endfunction

  function automatic op_t decode(input logic [4:0] op, input logic [1:0] f, input logic [3:0] im);
    op_t o;
    bit  r11 = (op == 5'b11011);
    bit  rsh = (op == 5'b11010);
    o = '{alu_op: 3'b000, default: 0};
    if (op inside {5'b01000, 5'b10000, 5'b10001, 5'b10011, 5'b11001, 5'b11111} ||
        (r11 && f == 2'd0)) begin
      o.alu_op = 3'b100;
    end else if (op inside {5'b01001, 5'b11100} || (r11 && f == 2'd1)) begin
      o.alu_op = 3'b100; o.inv_a = 1; o.cin = 1;
    end else if (op inside {5'b11101, 5'b11110}) begin
      o.alu_op = 3'b100; o.inv_b = 1; o.cin = 1;
    end else if (op == 5'b01010 || (r11 && f == 2'd2)) begin
      o.alu_op = 3'b110;
    end else if (op == 5'b01011 || (r11 && f == 2'd3)) begin
      o.alu_op = 3'b111; o.inv_b = 1;
    end else if (op inside {5'b10100, 5'b10101, 5'b10110, 5'b10111} || rsh) begin
      o.alu_op = rsh ? {1'b0, f} : {1'b0, op[1:0]};
      o.shift  = 1;
      o.flip   = (o.alu_op == 3'b010);
      o.r      = int'(im);
    end else if (op == 5'b10010) begin
      o.alu_op = 3'b001; o.shift = 1; o.slbi = 1; o.r = DW / 2;
    end else begin
      o.illegal = 1;
    end
    return o;
  endfunction

  function automatic bit exp_last(input int m);
    int left = cur[m].r - k[m] * stepm(m);
    return !cur[m].shift || (left <= stepm(m));
  endfunction

  function automatic logic [15:0] exp_obs(input int m);
    int left = cur[m].r - k[m] * stepm(m);
    int sh   = cur[m].shift ? ((left < stepm(m)) ? left : stepm(m)) : 0;
    bit last = exp_last(m);
    return {cur[m].alu_op, cur[m].inv_a, cur[m].inv_b, cur[m].cin, 4'(sh), cur[m].flip,
            cur[m].flip, cur[m].shift, cur[m].slbi && last, last, cur[m].illegal};
  endfunction

  function automatic bit exp_ready(input int m);
    return rst_n && !flush && (!busy[m] || (orr[m] && exp_last(m)));
  endfunction

  initial begin
    bit rdy;
    forever begin
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!rst_n) begin
          busy[m]  = 0;
          k[m]     = 0;
          zeros[m] = 1;
        end else begin
          zeros[m] = 0;
          if (flush) begin
            busy[m] = 0;
          end else begin
            rdy = exp_ready(m);
            if (busy[m] && orr[m]) begin
              if (exp_last(m)) busy[m] = 0;
              else k[m]++;
            end
            if (in_valid && rdy) begin
              cur[m]  = decode(opcode, func, immd);
              k[m]    = 0;
              busy[m] = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        string tag = (m == 0) ? "a" : "b";
        check({tag, ".out_valid"}, 32'(ov[m]), 32'(busy[m]));
        check({tag, ".in_ready"}, 32'(ir[m]), 32'(exp_ready(m)));
        if (busy[m]) check({tag, ".word"}, 32'(obs[m]), 32'(exp_obs(m)));
        else if (zeros[m]) check({tag, ".reset_word"}, 32'(obs[m]), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1);
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit acc;
    rst_n = 0; flush = 0; in_valid = 1; opcode = 5'b01000; func = 0; immd = 0; out_ready = 1;
    repeat (2) begin
      @(negedge clk);
      check("rst in_ready", 32'(bus_a.in_ready), 32'd0);
      check("rst out_valid", 32'(bus_a.out_valid), 32'd0);
      check("rst outputs", 32'(obs[0]), 32'd0);
    end
    tick();
    rst_n = 1; in_valid = 0;
    @(negedge clk);
    check("post-rst in_ready", 32'(bus_a.in_ready), 32'd1);

    // Decode sweep over every opcode/func pair.
    tick();
    for (int op = 0; op < 32; op++) begin
      for (int f = 0; f < 4; f++) begin
        opcode = 5'(op); func = 2'(f); immd = 4'(op + 3 * f); in_valid = 1;
        acc = 0;
        for (int w = 0; w < 16 && !acc; w++) begin
          @(negedge clk);
          acc = exp_ready(0);
          tick();
        end
        check("sweep accept", 32'(acc), 32'd1);
        if (op == 5'b11011 && f == 1) begin
          check("sub alu_op", 32'(bus_a.alu_op), 32'd4);
          check("sub inv_a", 32'(bus_a.inv_a), 32'd1);
          check("sub cin", 32'(bus_a.cin), 32'd1);
          check("sub last", 32'(bus_a.last_pass), 32'd1);
        end
        if (op == 0) check("op0 illegal", 32'(bus_a.illegal), 32'd1);
        if (op == 5'b10010) begin
          check("slbi b shamt", 32'(bus_b.shamt), 32'd8);
          check("slbi b slbi", 32'(bus_b.slbi), 32'd1);
          check("slbi a shamt", 32'(bus_a.shamt), 32'd4);
          check("slbi a slbi", 32'(bus_a.slbi), 32'd0);
        end
      end
    end
    in_valid = 0;
    repeat (6) tick();

    // SLLI by 11 over a 4-bit-per-pass shifter: 4, 4, 3.
    opcode = 5'b10101; immd = 4'd11; in_valid = 1;
    @(negedge clk);
    check("slli in_ready idle", 32'(bus_a.in_ready), 32'd1);
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("slli shamt", 32'(bus_a.shamt), (i == 2) ? 32'd3 : 32'd4);
      check("slli last", 32'(bus_a.last_pass), (i == 2) ? 32'd1 : 32'd0);
      check("slli in_ready", 32'(bus_a.in_ready), (i == 2) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clk);
    check("slli done", 32'(bus_a.out_valid), 32'd0);

    // RORI by 6 with three cycles of backpressure on the first pass.
    tick();
    opcode = 5'b10110; immd = 4'd6; in_valid = 1;
    tick();
    in_valid = 0; out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      check("rori hold shamt", 32'(bus_a.shamt), 32'd4);
      check("rori hold flips", 32'({bus_a.flip_1, bus_a.flip_2}), 32'd3);
      check("rori hold last", 32'(bus_a.last_pass), 32'd0);
      tick();
    end
    out_ready = 1;
    @(negedge clk);
    check("rori pass1 shamt", 32'(bus_a.shamt), 32'd4);
    tick();
    @(negedge clk);
    check("rori pass2 shamt", 32'(bus_a.shamt), 32'd2);
    check("rori pass2 last", 32'(bus_a.last_pass), 32'd1);
    check("rori pass2 flip", 32'(bus_a.flip_1), 32'd1);
    tick();

    // Five back-to-back ADDs.
    opcode = 5'b01000; func = 0; immd = 0; in_valid = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b out_valid", 32'(bus_a.out_valid), 32'd1);
      check("b2b in_ready", 32'(bus_a.in_ready), (i == 4) ? 32'd1 : 32'(in_valid));
      tick();
      if (i == 3) in_valid = 0;
    end
    @(negedge clk);
    check("b2b drained", 32'(bus_a.out_valid), 32'd0);

    // Flush, then reset, while SRLI by 15 is on its second pass.
    for (int v = 0; v < 2; v++) begin
      tick();
      opcode = 5'b10111; immd = 4'd15; in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      @(negedge clk);
      check("srli pass2 shamt", 32'(bus_a.shamt), 32'd4);
      tick();
      opcode = 5'b01000; in_valid = 1;
      if (v == 0) flush = 1;
      else rst_n = 0;
      @(negedge clk);
      check("abort in_ready", 32'(bus_a.in_ready), 32'd0);
      tick();
      flush = 0; rst_n = 1; in_valid = 0;
      @(negedge clk);
      check("abort out_valid", 32'(bus_a.out_valid), 32'd0);
      check("abort in_ready after", 32'(bus_a.in_ready), 32'd1);
      if (v == 1) check("reset outputs", 32'(obs[0]), 32'd0);
    end

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
